// File: rtl/serializador.sv
`timescale 1ns/1ps
// serializador: parallel-to-serial transmitter with a small input FIFO.
// Each queued word is sent as one frame: a preamble cycle (data_out=0),
// then DATA_WIDTH bits LSB first, with write_out high for the whole frame.
// After a frame the block idles GUARD_CYCLES cycles and then waits for the
// receiver to report free (status_in low) before starting the next frame.
module serializador #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned GUARD_CYCLES = 3
) (
  input  logic                          clock_100KHz,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          write_in,
  input  logic                          status_in,
  output logic                          data_out,
  output logic                          write_out,
  output logic                          frame_done,
  output logic                          busy_out,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow_out
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned GRD_W = $clog2(GUARD_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, START, SEND, GUARD, WAIT} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [DATA_WIDTH-1:0]   shreg;
  logic [BIT_W-1:0]        bit_cnt;
  logic [GRD_W-1:0]        guard_cnt;

  logic                    push_c;
  logic                    pop_c;
  logic                    stay_idle_c;
  logic [CNT_W-1:0]        count_nxt_c;

  // Queue handshake: a push is only taken with room at the edge; the pop
  // is the FSM launching a frame from IDLE.
  always_comb begin
    push_c      = write_in && (fifo_count < CNT_W'(FIFO_DEPTH));
    pop_c       = (state == IDLE) && (fifo_count != '0) && !status_in;
    count_nxt_c = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);
    stay_idle_c = ((state == IDLE) && !pop_c) || ((state == WAIT) && !status_in);
  end

  // FIFO storage (no reset needed, validity tracked by fifo_count)
  always_ff @(posedge clock_100KHz) begin
    if (push_c) mem[wr_ptr] <= data_in;
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clock_100KHz or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      fifo_full    <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (write_in && !push_c) overflow_out <= 1'b1;
      fifo_count <= count_nxt_c;
      fifo_full  <= (count_nxt_c == CNT_W'(FIFO_DEPTH));
    end
  end

  // Frame sequencer with registered line outputs
  always_ff @(posedge clock_100KHz or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      guard_cnt  <= '0;
      data_out   <= 1'b0;
      write_out  <= 1'b0;
      frame_done <= 1'b0;
      busy_out   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      busy_out   <= !stay_idle_c || (count_nxt_c != '0);
      case (state)
        IDLE: begin
          if (pop_c) begin
            shreg     <= mem[rd_ptr];
            write_out <= 1'b1;
            data_out  <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          data_out <= shreg[0];
          bit_cnt  <= '0;
          state    <= SEND;
        end
        SEND: begin
          if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
            write_out <= 1'b0;
            data_out  <= 1'b0;
            guard_cnt <= '0;
            state     <= GUARD;
          end else begin
            shreg    <= shreg >> 1;
            data_out <= shreg[1];
            bit_cnt  <= bit_cnt + BIT_W'(1);
          end
        end
        GUARD: begin
          if (guard_cnt == GRD_W'(GUARD_CYCLES - 1)) state <= WAIT;
          else guard_cnt <= guard_cnt + GRD_W'(1);
        end
        WAIT: begin
          if (!status_in) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serializador.sv
`timescale 1ns/1ps
// tb_serializador: directed vectors for the serial transmitter.
module tb_serializador;

  logic       clock_100KHz = 1'b0;
  logic       reset        = 1'b1;
  logic [7:0] data_in      = '0;
  logic       write_in     = 1'b0;
  logic       status_in    = 1'b0;
  logic       data_out, write_out, frame_done, busy_out, fifo_full, overflow_out;
  logic [2:0] fifo_count;

  int total = 0;
  int bad   = 0;

  serializador #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .GUARD_CYCLES(3)) dut (
    .clock_100KHz(clock_100KHz),
    .reset       (reset),
    .data_in     (data_in),
    .write_in    (write_in),
    .status_in   (status_in),
    .data_out    (data_out),
    .write_out   (write_out),
    .frame_done  (frame_done),
    .busy_out    (busy_out),
    .fifo_full   (fifo_full),
    .fifo_count  (fifo_count),
    .overflow_out(overflow_out)
  );

  always #5 clock_100KHz = ~clock_100KHz;

  // Frame pattern as seen on data_out: bit 0 = preamble, bits 1..8 = data LSB first
  typedef struct {
    logic [7:0] din;
    logic [8:0] seq;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_100KHz);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    data_in  = d;
    write_in = 1'b1;
    tick();
    write_in = 1'b0;
  endtask

  // Waits for a frame (bounded), records it, optionally pushes mid-frame
  task automatic frame(input string name, input int push_at, input logic [7:0] pd,
                       input logic [8:0] exp);
    logic [8:0] bits;
    int len;
    int waited;
    bits   = '0;
    len    = 0;
    waited = 0;
    while (!write_out && waited < 60) begin
      tick();
      waited++;
    end
    if (!write_out) begin
      check({name, "_start_timeout"}, 32'd0, 32'd1);
      return;
    end
    while (write_out && len < 16) begin
      if (len < 9) bits[len] = data_out;
      if (len == push_at) begin
        data_in  = pd;
        write_in = 1'b1;
      end
      tick();
      write_in = 1'b0;
      len++;
    end
    check({name, "_bits"}, 32'(bits), 32'(exp));
    check({name, "_len"}, 32'(len), 32'd9);
    check({name, "_line_low"}, 32'(data_out), 32'd0);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!frame_done && n < 20) begin
      tick();
      n++;
    end
    check({name, "_frame_done"}, 32'(frame_done), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy_out && n < 200) begin
      tick();
      n++;
    end
    check({name, "_idle"}, 32'(busy_out), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    logic [8:0] exp2[4];
    logic       act;
    int         g;

    vecs[0] = '{din: 8'hA5, seq: 9'h14A};
    vecs[1] = '{din: 8'h00, seq: 9'h000};
    vecs[2] = '{din: 8'hFF, seq: 9'h1FE};
    vecs[3] = '{din: 8'h3C, seq: 9'h078};
    exp2[0] = 9'h022;
    exp2[1] = 9'h044;
    exp2[2] = 9'h066;
    exp2[3] = 9'h088;

    #23;
    check("reset_outputs",
          32'({data_out, write_out, frame_done, busy_out, fifo_full, overflow_out}), 32'd0);
    check("reset_count", 32'(fifo_count), 32'd0);
    @(negedge clock_100KHz);
    reset = 1'b0;
    tick();

    // Single frames with latency checks
    for (int i = 0; i < 4; i++) begin
      push(vecs[i].din);
      check("lat_count_after_push", 32'(fifo_count), 32'd1);
      check("lat_write_low_at_E", 32'(write_out), 32'd0);
      tick();
      check("lat_write_high_at_E1", 32'({write_out, data_out}), 32'b10);
      frame("vec", -1, 8'h00, vecs[i].seq);
      wait_done("vec");
      check("vec_count_empty", 32'(fifo_count), 32'd0);
      check("vec_busy_low", 32'(busy_out), 32'd0);
      tick();
      check("vec_done_one_pulse", 32'(frame_done), 32'd0);
    end

    // Backpressure and overflow
    status_in = 1'b1;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    push(8'h55);
    check("ovf_count", 32'(fifo_count), 32'd4);
    check("ovf_full", 32'(fifo_full), 32'd1);
    check("ovf_flag", 32'(overflow_out), 32'd1);
    act = 1'b0;
    for (int k = 0; k < 4; k++) begin
      act = act | write_out;
      tick();
    end
    check("ovf_no_frame_while_busy", 32'(act), 32'd0);
    check("ovf_busy", 32'(busy_out), 32'd1);
    status_in = 1'b0;
    for (int k = 0; k < 4; k++) frame("ovf_drain", -1, 8'h00, exp2[k]);
    wait_idle("ovf");
    check("ovf_drain_count", 32'(fifo_count), 32'd0);
    check("ovf_sticky", 32'(overflow_out), 32'd1);

    // Receiver stays busy after a frame: next frame must hold off
    push(8'h5A);
    push(8'hC3);
    frame("hold_first", -1, 8'h00, 9'h0B4);
    status_in = 1'b1;
    act = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      act = act | write_out | frame_done;
    end
    check("hold_no_activity", 32'(act), 32'd0);
    status_in = 1'b0;
    frame("hold_second", -1, 8'h00, 9'h186);
    wait_done("hold");
    wait_idle("hold");

    // Reset in the middle of a frame
    push(8'hF0);
    push(8'h99);
    for (int k = 0; k < 5; k++) tick();
    check("rst_mid_bit4", 32'({write_out, data_out}), 32'b11);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_lines", 32'({write_out, data_out}), 32'd0);
    check("rst_mid_count", 32'(fifo_count), 32'd0);
    check("rst_mid_busy", 32'(busy_out), 32'd0);
    @(negedge clock_100KHz);
    reset = 1'b0;
    tick();
    push(8'h81);
    frame("rst_after", -1, 8'h00, 9'h102);
    wait_done("rst_after");
    wait_idle("rst_after");
    check("rst_ovf_cleared", 32'(overflow_out), 32'd0);

    // Push during a frame: first frame intact, second after guard + wait
    push(8'hAB);
    frame("mid_push_first", 4, 8'h12, 9'h156);
    check("mid_push_queued", 32'(fifo_count), 32'd1);
    g = 0;
    while (!write_out && g < 30) begin
      g++;
      tick();
    end
    check("mid_push_gap", 32'(g), 32'd5);
    frame("mid_push_second", -1, 8'h00, 9'h024);
    wait_done("mid_push");
    wait_idle("mid_push");

    // Push while full with a concurrent pop
    status_in = 1'b1;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h04);
    check("fullpop_pre_count", 32'(fifo_count), 32'd4);
    check("fullpop_pre_ovf", 32'(overflow_out), 32'd0);
    data_in   = 8'hEE;
    write_in  = 1'b1;
    status_in = 1'b0;
    tick();
    write_in = 1'b0;
    check("fullpop_count", 32'(fifo_count), 32'd3);
    check("fullpop_ovf", 32'(overflow_out), 32'd1);
    check("fullpop_started", 32'(write_out), 32'd1);
    frame("fullpop_f0", -1, 8'h00, 9'h002);
    frame("fullpop_f1", -1, 8'h00, 9'h004);
    frame("fullpop_f2", -1, 8'h00, 9'h006);
    frame("fullpop_f3", -1, 8'h00, 9'h008);
    wait_idle("fullpop");
    check("fullpop_empty", 32'(fifo_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
